// File: rtl/filt_ctrl_pkg.sv
// Shared types and 4-ASK level helper for the TX filter input sequencer.
package filt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Gray-coded 4-ASK symbol codes, ordered from most negative to most positive level
  localparam logic [1:0] CODE_NEG3 = 2'b00;
  localparam logic [1:0] CODE_NEG1 = 2'b01;
  localparam logic [1:0] CODE_POS1 = 2'b11;
  localparam logic [1:0] CODE_POS3 = 2'b10;

  function automatic int ask_level(input logic [1:0] code, input int amp);
    int lvl;
    case (code)
      CODE_NEG3: lvl = -3 * amp;
      CODE_NEG1: lvl = -amp;
      CODE_POS1: lvl = amp;
      CODE_POS3: lvl = 3 * amp;
      default:   lvl = 0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/ask4_map.sv
// Combinational 4-ASK mapper: symbol code to signed 1s17 level.
module ask4_map
  import filt_ctrl_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int AMP   = 32768
) (
  input  logic [1:0]       code,
  output logic [WIDTH-1:0] level
);

  // 3*AMP fits in WIDTH, so truncating the 32-bit level keeps the two's-complement value
  assign level = WIDTH'(ask_level(code, AMP));

endmodule

// File: rtl/filt_ctrl.sv
// Pulse-shaping filter input sequencer: symbol handshake, zero-insertion upsampling, flush.
// Define FILT_CTRL_ZOH_EN to hold each level for the whole symbol period instead.
module filt_ctrl
  import filt_ctrl_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int OSR       = 4,
  parameter int FLUSH_LEN = 21,
  parameter int AMP       = 32768
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       sym_in,
  input  logic             sym_valid,
  input  logic             sym_last,
  output logic             sym_ready,
  output logic [WIDTH-1:0] x_out,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int PHASE_W = $clog2(OSR);
  localparam int FLUSH_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OSR - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] phase, phase_nxt;
  logic [FLUSH_W-1:0] flush_cnt, flush_cnt_nxt;
  logic               last_seen, last_seen_nxt;
  logic [WIDTH-1:0]   level, x_nxt;
  logic               busy_nxt, done_nxt, underrun_nxt;
  logic               slot, accept;

  ask4_map #(
    .WIDTH (WIDTH),
    .AMP   (AMP)
  ) u_map (
    .code  (sym_in),
    .level (level)
  );

  // Once the last symbol is taken, the trailing phase-0 cycle is not a new slot
  assign slot      = (state == RUN) && (phase == '0) && !last_seen;
  assign sym_ready = slot;
  assign accept    = slot && sym_valid;

  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    flush_cnt_nxt = flush_cnt;
    last_seen_nxt = last_seen;
    underrun_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = RUN;
          phase_nxt     = '0;
          last_seen_nxt = 1'b0;
        end
      end
      RUN: begin
        phase_nxt = (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
        if (accept && sym_last) begin
          last_seen_nxt = 1'b1;
        end
        if (slot && !sym_valid) begin
          underrun_nxt = 1'b1;
        end
        if (last_seen && (phase == '0)) begin
          state_nxt     = FLUSH;
          phase_nxt     = '0;
          flush_cnt_nxt = '0;
          last_seen_nxt = 1'b0;
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_nxt     = IDLE;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt + FLUSH_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sample only carries a level while staying in RUN; entering FLUSH or IDLE forces zero
  always_comb begin
    x_nxt = '0;
    if (state_nxt == RUN) begin
      if (accept) begin
        x_nxt = level;
      end else begin
`ifdef FILT_CTRL_ZOH_EN
        x_nxt = x_out;
`else
        x_nxt = '0;
`endif
      end
    end
  end

  assign busy_nxt = (state_nxt != IDLE);
  assign done_nxt = (state_nxt == FLUSH) && (flush_cnt_nxt == FLUSH_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= '0;
      flush_cnt <= '0;
      last_seen <= 1'b0;
      x_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      flush_cnt <= flush_cnt_nxt;
      last_seen <= last_seen_nxt;
      x_out     <= x_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      underrun  <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_filt_ctrl.sv
// Scoreboard bench for filt_ctrl: expected per-cycle samples are queued when symbols are driven.
module tb_filt_ctrl;

  localparam int OSR       = 4;
  localparam int FLUSH_LEN = 21;

  typedef struct packed {
    logic [17:0] x;
    logic        done;
    logic        underrun;
    logic        busy;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  sym_in;
  logic        sym_valid;
  logic        sym_last;
  logic        sym_ready;
  logic [17:0] x_out;
  logic        busy;
  logic        done;
  logic        underrun;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic [17:0] hold;

  int         sc_n     [3]    = '{1, 4, 3};
  logic [1:0] sc_sym   [3][4] = '{'{2'b10, 2'b00, 2'b00, 2'b00},
                                  '{2'b00, 2'b01, 2'b11, 2'b10},
                                  '{2'b01, 2'b00, 2'b11, 2'b00}};
  logic       sc_valid [3][4] = '{'{1'b1, 1'b1, 1'b1, 1'b1},
                                  '{1'b1, 1'b1, 1'b1, 1'b1},
                                  '{1'b1, 1'b0, 1'b1, 1'b1}};
  string      sc_name  [3]    = '{"single", "four_level", "underrun"};

  filt_ctrl #(
    .WIDTH     (18),
    .OSR       (OSR),
    .FLUSH_LEN (FLUSH_LEN),
    .AMP       (32768)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_last  (sym_last),
    .sym_ready (sym_ready),
    .x_out     (x_out),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] model_level(input logic [1:0] c);
    case (c)
      2'b00:   return 18'(-98304);
      2'b01:   return 18'(-32768);
      2'b11:   return 18'(32768);
      default: return 18'(98304);
    endcase
  endfunction

  task automatic push_sym(input logic [1:0] c);
    exp_t e;
    hold = model_level(c);
    e = '{x: hold, done: 1'b0, underrun: 1'b0, busy: 1'b1};
    exp_q.push_back(e);
`ifndef FILT_CTRL_ZOH_EN
    hold = '0;
`endif
    for (int i = 1; i < OSR; i++) begin
      e = '{x: hold, done: 1'b0, underrun: 1'b0, busy: 1'b1};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_underrun();
    exp_t e;
    for (int i = 0; i < OSR; i++) begin
      e = '{x: hold, done: 1'b0, underrun: (i == 0), busy: 1'b1};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_flush();
    exp_t e;
    hold = '0;
    for (int i = 0; i < FLUSH_LEN; i++) begin
      e = '{x: 18'd0, done: (i == FLUSH_LEN - 1), underrun: 1'b0, busy: 1'b1};
      exp_q.push_back(e);
    end
    e = '{x: 18'd0, done: 1'b0, underrun: 1'b0, busy: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (21) begin
      @(negedge clk);
      vectors++;
      if ({x_out, done, underrun, busy, sym_ready} !== 22'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold: x=%0d done=%b und=%b busy=%b ready=%b, required all zero",
                 $signed(x_out), done, underrun, busy, sym_ready);
      end
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if ({x_out, done, underrun, busy, sym_ready} !== 22'd0) begin
        miscompares++;
        $display("[TB] FAIL idle_no_start: x=%0d done=%b und=%b busy=%b ready=%b, required all zero",
                 $signed(x_out), done, underrun, busy, sym_ready);
      end
    end
  endtask

  task automatic test_bursts();
    for (int s = 0; s < 3; s++) begin
      int   c;
      int   slot;
      exp_t e;
      exp_t o;
      logic ready_exp;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hold  = '0;
      c     = 0;
      slot  = 0;
      while (1) begin
        if (c > 0) begin
          if (exp_q.size() == 0) break;
          e = exp_q.pop_front();
          o = {x_out, done, underrun, busy};
          vectors++;
          if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL %s cyc%0d: x=%0d done=%b und=%b busy=%b, required x=%0d done=%b und=%b busy=%b",
                     sc_name[s], c, $signed(o.x), o.done, o.underrun, o.busy,
                     $signed(e.x), e.done, e.underrun, e.busy);
          end
        end
        ready_exp = ((c % OSR) == 0) && (slot < sc_n[s]);
        vectors++;
        if (sym_ready !== ready_exp) begin
          miscompares++;
          $display("[TB] FAIL %s ready cyc%0d: got %b, required %b", sc_name[s], c, sym_ready, ready_exp);
        end
        if (ready_exp) begin
          start     = 1'b0;
          sym_valid = sc_valid[s][slot];
          sym_in    = sc_sym[s][slot];
          sym_last  = (slot == sc_n[s] - 1) || !sc_valid[s][slot];
          if (sc_valid[s][slot]) push_sym(sc_sym[s][slot]);
          else push_underrun();
          if (slot == sc_n[s] - 1) push_flush();
          slot++;
        end else begin
          sym_valid = 1'($urandom_range(0, 1));
          sym_in    = 2'($urandom_range(0, 3));
          sym_last  = 1'($urandom_range(0, 1));
          start     = (slot < sc_n[s]) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        c++;
        if (c > 200) begin
          miscompares++;
          $display("[TB] FAIL %s timeout: %0d expected samples left, required 0", sc_name[s], exp_q.size());
          break;
        end
        @(negedge clk);
      end
      exp_q.delete();
      start     = 1'b0;
      sym_valid = 1'b0;
      sym_last  = 1'b0;
    end
  endtask

  task automatic test_reset_mid_flush();
    exp_t e;
    exp_t o;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    hold      = '0;
    sym_in    = 2'b11;
    sym_valid = 1'b1;
    sym_last  = 1'b1;
    push_sym(2'b11);
    push_flush();
    // k = 14 is the tenth FLUSH cycle (first FLUSH cycle is acceptance + OSR + 1)
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      sym_valid = 1'b0;
      sym_last  = 1'b0;
      start     = (k == 2);
      e = exp_q.pop_front();
      o = {x_out, done, underrun, busy};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL mid_flush cyc%0d: x=%0d done=%b und=%b busy=%b, required x=%0d done=%b und=%b busy=%b",
                 k, $signed(o.x), o.done, o.underrun, o.busy, $signed(e.x), e.done, e.underrun, e.busy);
      end
    end
    exp_q.delete();
    reset = 1'b0;
    #1;
    vectors++;
    if ({x_out, done, underrun, busy, sym_ready} !== 22'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: x=%0d done=%b und=%b busy=%b ready=%b, required all zero",
               $signed(x_out), done, underrun, busy, sym_ready);
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({done, busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL reset_no_done: done=%b busy=%b, required 0 0", done, busy);
      end
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if ({x_out, done, underrun, busy, sym_ready} !== 22'd0) begin
        miscompares++;
        $display("[TB] FAIL idle_after_reset: x=%0d done=%b und=%b busy=%b ready=%b, required all zero",
                 $signed(x_out), done, underrun, busy, sym_ready);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    sym_in    = 2'b00;
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    hold      = '0;
    test_reset();
    test_bursts();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
